// File: rtl/trap_controller_pkg.sv
// Shared definitions for the trap controller.
// Holds the trap request codes (trap_status encodings), the sequencer state
// encoding, the machine-mode CSR addresses touched by the trap sequence and
// the mcause values for each synchronous exception.
package trap_controller_pkg;

   typedef enum logic [2:0] {
      TS_NONE         = 3'd0,
      TS_ECALL        = 3'd1,
      TS_EBREAK       = 3'd2,
      TS_ILLEGAL      = 3'd3,
      TS_MIS_INSTR    = 3'd4,
      TS_MIS_LOAD     = 3'd5,
      TS_MIS_STORE    = 3'd6,
      TS_MRET         = 3'd7
   } trap_status_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DRAIN,
      ST_W_MEPC,
      ST_W_MCAUSE,
      ST_W_MTVAL,
      ST_R_MTVEC,
      ST_R_MEPC,
      ST_REDIRECT
   } trap_state_e;

   localparam logic [11:0] CSR_MTVEC  = 12'h305;
   localparam logic [11:0] CSR_MEPC   = 12'h341;
   localparam logic [11:0] CSR_MCAUSE = 12'h342;
   localparam logic [11:0] CSR_MTVAL  = 12'h343;

   localparam logic [31:0] MCAUSE_MIS_INSTR = 32'd0;
   localparam logic [31:0] MCAUSE_ILLEGAL   = 32'd2;
   localparam logic [31:0] MCAUSE_EBREAK    = 32'd3;
   localparam logic [31:0] MCAUSE_MIS_LOAD  = 32'd4;
   localparam logic [31:0] MCAUSE_MIS_STORE = 32'd6;
   localparam logic [31:0] MCAUSE_ECALL     = 32'd11;

   function automatic logic [31:0] mcause_of(input trap_status_e code);
      logic [31:0] cause;
      cause = '0;
      case (code)
         TS_ECALL:     cause = MCAUSE_ECALL;
         TS_EBREAK:    cause = MCAUSE_EBREAK;
         TS_ILLEGAL:   cause = MCAUSE_ILLEGAL;
         TS_MIS_INSTR: cause = MCAUSE_MIS_INSTR;
         TS_MIS_LOAD:  cause = MCAUSE_MIS_LOAD;
         TS_MIS_STORE: cause = MCAUSE_MIS_STORE;
         default:      cause = '0;
      endcase
      return cause;
   endfunction

endpackage

// File: rtl/trap_controller.sv
// Trap controller: sequences the CSR accesses needed to take a synchronous
// exception or return from one, then redirects the PC and flushes the pipe.
//
// Optional feature: define TRAP_MTVAL_EN to include the mtval write step;
// without it mcause is followed directly by the mtvec read and trap_tval
// is ignored.
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   trap_status[2:0]      trap request code (trap_status_e)
//   trap_pc, trap_tval    PC and faulting value of the trapping instruction
//   csr_read_data         CSR read result, valid with csr_ready
//   csr_ready             CSR file completed the current access
//   csr_write_enable      CSR write strobe
//   csr_access_address    CSR address of the current access
//   csr_write_data        CSR write data
//   trap_target           redirect PC (meaningful with trap_redirect)
//   trap_redirect         one-cycle PC load strobe
//   trap_done             no trap sequence in progress (idle or draining)
//   standby_mode          ID-phase drain in progress
//   pth_done_flush        one-cycle flush of all pipeline registers
module trap_controller
   import trap_controller_pkg::*;
#(
   parameter int DRAIN_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  trap_status,
   input  logic [31:0] trap_pc,
   input  logic [31:0] trap_tval,
   input  logic [31:0] csr_read_data,
   input  logic        csr_ready,
   output logic        csr_write_enable,
   output logic [11:0] csr_access_address,
   output logic [31:0] csr_write_data,
   output logic [31:0] trap_target,
   output logic        trap_redirect,
   output logic        trap_done,
   output logic        standby_mode,
   output logic        pth_done_flush
);

   localparam int CW = $clog2(DRAIN_CYCLES + 1);

   trap_state_e  state_q, state_d;
   trap_status_e code_q, code_d;
   logic [29:0]  pc_q, pc_d;       // word-aligned PC, low bits are always 0
   logic [CW-1:0] cnt_q, cnt_d;
   logic [29:0]  target_q, target_d;
   trap_status_e req;

`ifdef TRAP_MTVAL_EN
   logic [31:0]  tval_q, tval_d;
   logic         unused_bits;
   assign unused_bits = ^{csr_read_data[1:0], trap_pc[1:0]};
`else
   logic         unused_bits;
   assign unused_bits = ^{csr_read_data[1:0], trap_pc[1:0], trap_tval};
`endif

   assign req         = trap_status_e'(trap_status);
   assign trap_target = {target_q, 2'b00};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         code_q   <= TS_NONE;
         pc_q     <= '0;
         cnt_q    <= '0;
         target_q <= '0;
`ifdef TRAP_MTVAL_EN
         tval_q   <= '0;
`endif
      end else begin
         state_q  <= state_d;
         code_q   <= code_d;
         pc_q     <= pc_d;
         cnt_q    <= cnt_d;
         target_q <= target_d;
`ifdef TRAP_MTVAL_EN
         tval_q   <= tval_d;
`endif
      end
   end

   always_comb begin
      state_d            = state_q;
      code_d             = code_q;
      pc_d               = pc_q;
      cnt_d              = cnt_q;
      target_d           = target_q;
`ifdef TRAP_MTVAL_EN
      tval_d             = tval_q;
`endif
      csr_write_enable   = 1'b0;
      csr_access_address = '0;
      csr_write_data     = '0;
      trap_redirect      = 1'b0;
      pth_done_flush     = 1'b0;
      trap_done          = 1'b0;
      standby_mode       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            trap_done = 1'b1;
            case (req)
               TS_ECALL, TS_EBREAK, TS_ILLEGAL: begin
                  code_d  = req;
                  pc_d    = trap_pc[31:2];
`ifdef TRAP_MTVAL_EN
                  tval_d  = trap_tval;
`endif
                  cnt_d   = CW'(DRAIN_CYCLES - 1);
                  state_d = ST_DRAIN;
               end
               TS_MIS_INSTR, TS_MIS_LOAD, TS_MIS_STORE: begin
                  code_d  = req;
                  pc_d    = trap_pc[31:2];
`ifdef TRAP_MTVAL_EN
                  tval_d  = trap_tval;
`endif
                  state_d = ST_W_MEPC;
               end
               TS_MRET:  state_d = ST_R_MEPC;
               default:  state_d = ST_IDLE;
            endcase
         end
         // Counter starts at DRAIN_CYCLES-1 and the exit happens on the
         // cycle it reads 0, giving exactly DRAIN_CYCLES cycles here.
         ST_DRAIN: begin
            trap_done    = 1'b1;
            standby_mode = 1'b1;
            if (cnt_q == '0) state_d = ST_W_MEPC;
            else             cnt_d   = cnt_q - CW'(1);
         end
         ST_W_MEPC: begin
            csr_write_enable   = 1'b1;
            csr_access_address = CSR_MEPC;
            csr_write_data     = {pc_q, 2'b00};
            if (csr_ready) state_d = ST_W_MCAUSE;
         end
         ST_W_MCAUSE: begin
            csr_write_enable   = 1'b1;
            csr_access_address = CSR_MCAUSE;
            csr_write_data     = mcause_of(code_q);
`ifdef TRAP_MTVAL_EN
            if (csr_ready) state_d = ST_W_MTVAL;
`else
            if (csr_ready) state_d = ST_R_MTVEC;
`endif
         end
         ST_W_MTVAL: begin
`ifdef TRAP_MTVAL_EN
            csr_write_enable   = 1'b1;
            csr_access_address = CSR_MTVAL;
            csr_write_data     = tval_q;
            if (csr_ready) state_d = ST_R_MTVEC;
`else
            state_d = ST_IDLE;
`endif
         end
         ST_R_MTVEC: begin
            csr_access_address = CSR_MTVEC;
            if (csr_ready) begin
               target_d = csr_read_data[31:2];
               state_d  = ST_REDIRECT;
            end
         end
         ST_R_MEPC: begin
            csr_access_address = CSR_MEPC;
            if (csr_ready) begin
               target_d = csr_read_data[31:2];
               state_d  = ST_REDIRECT;
            end
         end
         ST_REDIRECT: begin
            trap_redirect  = 1'b1;
            pth_done_flush = 1'b1;
            state_d        = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_trap_controller.sv
// Scoreboard bench for trap_controller: the stimulus process pushes the
// CSR accesses and redirect each request should produce; a monitor pops
// and compares whenever the DUT completes a CSR access or redirects.
module tb_trap_controller;
   import trap_controller_pkg::*;

   localparam int DC = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  trap_status;
   logic [31:0] trap_pc, trap_tval, csr_read_data;
   logic        csr_ready;
   logic        csr_write_enable, trap_redirect, trap_done, standby_mode, pth_done_flush;
   logic [11:0] csr_access_address;
   logic [31:0] csr_write_data, trap_target;

   int checks   = 0;
   int failures = 0;

   // kind: 0 = CSR write, 1 = CSR read, 2 = redirect
   typedef struct {
      int          kind;
      logic [11:0] addr;
      logic [31:0] data;
   } ev_t;
   ev_t exp_q[$];

   logic [31:0] cur_mtvec = 32'h0;
   logic [31:0] cur_mepc  = 32'h0;

   trap_controller #(.DRAIN_CYCLES(DC)) dut (
      .clk(clk), .reset(reset), .trap_status(trap_status), .trap_pc(trap_pc),
      .trap_tval(trap_tval), .csr_read_data(csr_read_data), .csr_ready(csr_ready),
      .csr_write_enable(csr_write_enable), .csr_access_address(csr_access_address),
      .csr_write_data(csr_write_data), .trap_target(trap_target),
      .trap_redirect(trap_redirect), .trap_done(trap_done),
      .standby_mode(standby_mode), .pth_done_flush(pth_done_flush)
   );

   always #5 clk = ~clk;

   // Simple CSR file: only mtvec and mepc are ever read by the sequence.
   always_comb begin
      csr_read_data = 32'h0;
      if (csr_access_address == 12'h305)      csr_read_data = cur_mtvec;
      else if (csr_access_address == 12'h341) csr_read_data = cur_mepc;
   end

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic logic [31:0] cause_ref(input logic [2:0] code);
      case (code)
         3'd1:    return 32'd11;
         3'd2:    return 32'd3;
         3'd3:    return 32'd2;
         3'd4:    return 32'd0;
         3'd5:    return 32'd4;
         3'd6:    return 32'd6;
         default: return 32'hdead;
      endcase
   endfunction

   // Monitor
   logic [11:0] prev_addr = '0;
   logic [31:0] prev_data = '0;
   logic        prev_we = 1'b0, prev_ready = 1'b1;

   always @(negedge clk) begin
      if (!reset) begin
         if (prev_addr != 12'h0 && !prev_ready)
            chk("hold_stable", {19'h0, csr_write_enable, csr_access_address},
                {19'h0, prev_we, prev_addr});
         if (prev_addr != 12'h0 && !prev_ready && prev_we)
            chk("hold_data", csr_write_data, prev_data);
         if (csr_access_address != 12'h0 && csr_ready) begin
            chk("busy_done", {31'h0, trap_done}, 32'h0);
            if (exp_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_access: got addr %h expected none", csr_access_address);
            end else begin
               ev_t e;
               e = exp_q.pop_front();
               chk("access_kind", {31'h0, csr_write_enable}, (e.kind == 0) ? 32'h1 : 32'h0);
               chk("access_addr", {20'h0, csr_access_address}, {20'h0, e.addr});
               if (e.kind == 0) chk("write_data", csr_write_data, e.data);
            end
         end
         if (trap_redirect) begin
            chk("redirect_flush", {30'h0, pth_done_flush, trap_done}, 32'h2);
            if (exp_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_redirect: got target %h expected none", trap_target);
            end else begin
               ev_t e;
               e = exp_q.pop_front();
               chk("redirect_kind", e.kind, 2);
               chk("redirect_target", trap_target, e.data);
            end
         end
      end
      prev_addr  <= reset ? 12'h0 : csr_access_address;
      prev_data  <= csr_write_data;
      prev_we    <= csr_write_enable;
      prev_ready <= csr_ready;
   end

   task automatic push(input int kind, input logic [11:0] addr, input logic [31:0] data);
      ev_t e;
      e.kind = kind; e.addr = addr; e.data = data;
      exp_q.push_back(e);
   endtask

   task automatic expect_trap(input logic [2:0] code, input logic [31:0] pc, input logic [31:0] tval);
      if (code == 3'd7) begin
         push(1, 12'h341, 32'h0);
         push(2, 12'h0, {cur_mepc[31:2], 2'b00});
      end else begin
         push(0, 12'h341, {pc[31:2], 2'b00});
         push(0, 12'h342, cause_ref(code));
`ifdef TRAP_MTVAL_EN
         push(0, 12'h343, tval);
`endif
         push(1, 12'h305, 32'h0);
         push(2, 12'h0, {cur_mtvec[31:2], 2'b00});
         cur_mepc = {pc[31:2], 2'b00};
      end
   endtask

   // rdy_mode: 1 = csr_ready always high, 0 = random
   task automatic run_trap(input logic [2:0] code, input logic [31:0] pc,
                           input logic [31:0] tval, input bit rdy_mode);
      int  sb;
      int  nd;
      bit  seen;
      expect_trap(code, pc, tval);
      trap_status = code; trap_pc = pc; trap_tval = tval;
      csr_ready = 1'b1;
      @(posedge clk); #1;
      sb = 0; nd = 0; seen = 1'b0;
      for (int cyc = 0; cyc < 300 && !seen; cyc++) begin
         trap_status = 3'($urandom);
         trap_pc     = $urandom;
         trap_tval   = $urandom;
         csr_ready   = rdy_mode ? 1'b1 : ($urandom_range(9, 0) < 6);
         @(negedge clk);
         if (standby_mode) sb++;
         if (trap_done && !standby_mode) nd++;
         if (trap_redirect) seen = 1'b1;
         @(posedge clk); #1;
      end
      trap_status = 3'd0;
      chk("redirect_seen", {31'h0, seen}, 32'h1);
      chk("drain_cycles", sb, (code >= 3'd1 && code <= 3'd3) ? DC : 0);
      chk("done_low_in_seq", nd, 0);
      @(negedge clk);
      chk("idle_outputs", {26'h0, trap_done, standby_mode, csr_write_enable,
                           trap_redirect, pth_done_flush, csr_access_address == 12'h0},
          32'b100001);
      @(posedge clk); #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int reds;
      reset = 1'b1; trap_status = 3'd0; trap_pc = '0; trap_tval = '0; csr_ready = 1'b0;
      @(posedge clk); #1;
      chk("reset_outputs", {26'h0, trap_done, standby_mode, csr_write_enable,
                            trap_redirect, pth_done_flush, csr_access_address == 12'h0},
          32'b100001);
      chk("reset_target", trap_target, 32'h0);
      chk("reset_wdata", csr_write_data, 32'h0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      // ECALL at 0x100 with csr_ready held high, mtvec = 0x2001
      cur_mtvec = 32'h2001;
      run_trap(3'd1, 32'h100, 32'h0, 1'b1);
      // Misaligned load with tval 0x3
      run_trap(3'd5, 32'h204, 32'h3, 1'b1);
      // MRET with mepc = 0x104
      cur_mepc = 32'h104;
      run_trap(3'd7, 32'h0, 32'h0, 1'b1);

      for (int n = 0; n < 60; n++) begin
         logic [2:0] code;
         code = 3'($urandom_range(7, 1));
         cur_mtvec = $urandom;
         if (code == 3'd7 && $urandom_range(1, 0) == 1) cur_mepc = $urandom;
         run_trap(code, $urandom, $urandom, 1'b0);
      end
      chk("queue_drained", exp_q.size(), 0);

      // Reset while waiting in R_MTVEC
      cur_mtvec = 32'h4000;
      expect_trap(3'd3, 32'h300, 32'h55);
      trap_status = 3'd3; trap_pc = 32'h300; trap_tval = 32'h55;
      csr_ready = 1'b1;
      @(posedge clk); #1;
      trap_status = 3'd0;
      for (int cyc = 0; cyc < 50 && csr_access_address != 12'h305; cyc++) begin
         @(posedge clk); #1;
      end
      chk("reached_rmtvec", {20'h0, csr_access_address}, 32'h305);
      csr_ready = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("async_reset_done", {31'h0, trap_done}, 32'h1);
      chk("async_reset_addr", {20'h0, csr_access_address}, 32'h0);
      @(posedge clk); #1;
      exp_q.delete();
      reset = 1'b0;
      reds = 0;
      for (int cyc = 0; cyc < 12; cyc++) begin
         csr_ready = $urandom_range(1, 0);
         @(negedge clk);
         if (trap_redirect) reds++;
         @(posedge clk); #1;
      end
      chk("no_redirect_after_reset", reds, 0);
      chk("idle_after_reset", {30'h0, trap_done, standby_mode}, 32'h2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/trap_controller.md
TRAP_CONTROLLER -- requirements
Module: trap_controller

Interface
REQ-001 The block SHALL have parameter DRAIN_CYCLES, default 2, the number of cycles older instructions get to retire before an ID-phase trap is taken.
REQ-002 clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 trap_status  input  3  trap request code from trap.vh: NONE, ECALL, EBREAK, ILLEGAL, MISALIGNED_INSTRUCTION, MISALIGNED_LOAD, MISALIGNED_STORE, MRET.
REQ-005 trap_pc  input  32  PC of the trapping instruction.
REQ-006 trap_tval  input  32  faulting address or instruction word.
REQ-007 csr_read_data  input  32  CSR read result, valid when csr_ready=1.
REQ-008 csr_ready  input  1  CSR file has completed the current access.
REQ-009 csr_write_enable  output  1  trap-side CSR write strobe.
REQ-010 csr_access_address  output  12  CSR address for the current read or write.
REQ-011 csr_write_data  output  32  CSR write data.
REQ-012 trap_target  output  32  redirect PC, valid while trap_redirect=1.
REQ-013 trap_redirect  output  1  one-cycle PC load strobe.
REQ-014 trap_done  output  1  high when no trap sequence is in progress; the hazard unit stalls all stages while it is low.
REQ-015 standby_mode  output  1  high during the ID-phase drain; the hazard unit stalls IF/ID and ID/EX only.
REQ-016 pth_done_flush  output  1  one-cycle pulse that flushes all four pipeline registers.

Function
REQ-017 The FSM SHALL have states IDLE, DRAIN, W_MEPC, W_MCAUSE, W_MTVAL, R_MTVEC, R_MEPC and REDIRECT.
REQ-018 In IDLE, trap_status of ECALL, EBREAK or ILLEGAL SHALL latch trap_pc, trap_tval and the code, load the drain counter with DRAIN_CYCLES-1, and go to DRAIN.
REQ-019 In IDLE, a MISALIGNED_* code SHALL latch the same values and go directly to W_MEPC.
REQ-020 In IDLE, MRET SHALL go to R_MEPC.
REQ-021 In DRAIN, standby_mode=1 and trap_done=1; the counter SHALL decrement each cycle, and the FSM SHALL go to W_MEPC the cycle after the counter reaches 0, i.e. after exactly DRAIN_CYCLES cycles in DRAIN.
REQ-022 In every state other than IDLE and DRAIN, trap_done SHALL be 0.
REQ-023 In W_MEPC, the block SHALL drive address 0x341 with data {latched_pc[31:2],2'b00}.
REQ-024 In W_MCAUSE, the block SHALL drive address 0x342 with cause: ECALL 11, EBREAK 3, ILLEGAL 2, MISALIGNED_INSTRUCTION 0, MISALIGNED_LOAD 4, MISALIGNED_STORE 6.
REQ-025 In W_MTVAL, the block SHALL drive address 0x343 with latched_tval.
REQ-026 In R_MTVEC, the block SHALL drive address 0x305 with csr_write_enable=0.
REQ-027 In R_MEPC, the block SHALL drive address 0x341 with csr_write_enable=0.
REQ-028 Every CSR state SHALL hold its address, data and enable unchanged until csr_ready=1, then advance on that edge; the sequence is W_MEPC→W_MCAUSE→W_MTVAL→R_MTVEC→REDIRECT, and R_MEPC→REDIRECT.
REQ-029 On the csr_ready edge in R_MTVEC or R_MEPC, the block SHALL capture csr_read_data with bits [1:0] forced to 0 as the target; only direct-mode mtvec is supported.
REQ-030 REDIRECT SHALL last exactly 1 cycle with trap_redirect=1, pth_done_flush=1 and trap_target=captured target, then return to IDLE.
REQ-031 While the FSM is outside IDLE, changes on trap_status SHALL be ignored; only the latched request is serviced.
REQ-032 In IDLE with trap_status=NONE, all strobes SHALL be 0 and trap_done=1.
REQ-033 A reset asserted mid-sequence SHALL abandon the sequence and issue no further CSR access.

Reset
REQ-034 While reset is high, the FSM SHALL be in IDLE with trap_done=1 and all other outputs, latches and the counter at 0.

Configuration
REQ-035 With TRAP_MTVAL_EN defined, W_MTVAL SHALL be present; without it, W_MCAUSE SHALL go directly to R_MTVEC, mtval SHALL never be written, and trap_tval SHALL be unused.

Structure
REQ-036 The state encoding, CSR addresses (0x305/0x341/0x342/0x343) and mcause codes SHALL live in the shared header beside trap.vh; trap_status encodings SHALL come from trap.vh.
REQ-037 The block SHALL be a single module with no sub-module.

Verification
REQ-038 ECALL at trap_pc=0x100 with DRAIN_CYCLES=2 and csr_ready held high -> standby_mode for 2 cycles, then writes mepc=0x100 and mcause=11, reads mtvec=0x2001, redirect to 0x2000 with pth_done_flush for 1 cycle.
REQ-039 MISALIGNED_LOAD with tval=0x3 under TRAP_MTVAL_EN -> no DRAIN; mcause=4, mtval=0x3; the same case without the macro -> no 0x343 write.
REQ-040 MRET with mepc=0x104 -> one read of 0x341, then trap_redirect with target 0x104 and trap_done=0 only during R_MEPC/REDIRECT.
REQ-041 csr_ready held low for 3 cycles in W_MCAUSE -> address and data stable for 4 cycles; trap_status changes during that time are ignored.
REQ-042 reset pulsed during R_MTVEC -> IDLE immediately, trap_done=1, and no trap_redirect afterwards.
